// File: rtl/demux_route_sched.sv
// demux_route_sched
//   Sequencing controller for the 16-bit 1-to-2 result demultiplexer.
//   Tagged results arrive over a valid/ready handshake and are buffered in a
//   DEPTH-entry FIFO. They are delivered strictly in arrival order to
//   destination A (tag 0) or destination B (tag 1) through one output
//   register. A stalled destination blocks the other (head-of-line).
//
// Handshake rule (every port pair): a word transfers on the rising clk edge
//   where valid && ready. Once valid is raised, valid and data hold steady
//   until that transfer. Only reset may drop valid without a transfer.
//
// Parameters
//   DEPTH     FIFO entries, power of two, 2..16
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_dest       result word and destination tag (0=A, 1=B)
//   in_valid/in_ready     producer handshake; in_ready is low while rst is high
//   a_data/a_valid/a_ready  destination A; a_data is 0 when a_valid is low
//   b_data/b_valid/b_ready  destination B; b_data is 0 when b_valid is low
//   busy                  FIFO non-empty or output register occupied
//   cnt_a/cnt_b           completed A/B transfers, wrapping 16-bit
//                         (present only when ROUTE_CNT_EN is defined)
// Debug: the FSM state is held in the typed signal `state` (state_t).
module demux_route_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_dest,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a_data,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [15:0] b_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        busy
`ifdef ROUTE_CNT_EN
  ,
  output logic [15:0] cnt_a,
  output logic [15:0] cnt_b
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [16:0]   out_q;
  logic [16:0]   head;
  logic          empty;
  logic          push;
  logic          pop;
  logic          out_free;

  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT) && !rst;
  assign push     = in_valid && in_ready;

  // Output register is free to reload when it is empty (IDLE) or its word
  // is leaving this cycle; that lets a pop and a handshake share one cycle.
  assign out_free = (state == IDLE) ||
                    ((state == SEND_A) && a_ready) ||
                    ((state == SEND_B) && b_ready);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    if (out_free) begin
      if (!empty) begin
        pop      = 1'b1;
        state_nx = head[16] ? SEND_B : SEND_A;
      end else begin
        state_nx = IDLE;
      end
    end
    if (state != IDLE && state != SEND_A && state != SEND_B) begin
      state_nx = IDLE;
      pop      = 1'b0;
    end
  end

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dest, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_q  <= '0;
      state  <= IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        out_q  <= head;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      state <= state_nx;
    end
  end

  assign a_valid = (state == SEND_A);
  assign b_valid = (state == SEND_B);
  assign a_data  = a_valid ? out_q[15:0] : 16'h0000;
  assign b_data  = b_valid ? out_q[15:0] : 16'h0000;
  assign busy    = !empty || (state != IDLE);

`ifdef ROUTE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_valid && a_ready) begin
        cnt_a <= cnt_a + 16'd1;
      end
      if (b_valid && b_ready) begin
        cnt_b <= cnt_b + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/demux_route_sched.md
# demux_route_sched

Sequencing controller for the 16-bit 1-to-2 result demultiplexer in the processor datapath. Accepts tagged 16-bit results from the execute stage through a valid/ready handshake and buffers them in a small FIFO. Routes each result, in arrival order, to destination A (register-file write port) or destination B (output/memory port) with independent per-destination backpressure. The non-selected side always sees zero data, matching the demux convention.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_data`  input  16  result word
- `in_dest`  input  1  destination tag: 0 = A, 1 = B
- `in_valid`  input  1  producer offers `in_data`/`in_dest`
- `in_ready`  output  1  FIFO can accept; transfer when `in_valid && in_ready`
- `a_data`  output  16  data to destination A; 0 when `a_valid` low
- `a_valid`  output  1  A word pending
- `a_ready`  input  1  A accepts; transfer when `a_valid && a_ready`
- `b_data`  output  16  data to destination B; 0 when `b_valid` low
- `b_valid`  output  1  B word pending
- `b_ready`  input  1  B accepts
- `busy`  output  1  FIFO non-empty or output register occupied
- `cnt_a`  output  16  completed A transfers (only with `ROUTE_CNT_EN`)
- `cnt_b`  output  16  completed B transfers (only with `ROUTE_CNT_EN`)

## Operation
- FIFO: DEPTH x 17 bits ({dest, data}), with wrapping read/write pointers and an occupancy count 0..DEPTH.
  - `in_ready` = !full && !rst (combinational).
  - A push never occurs when full.
  - Simultaneous push and pop are both honoured; occupancy is unchanged.
- Output register holds {dest, data}. FSM states:
  - IDLE: `a_valid`=`b_valid`=0. If FIFO non-empty: pop the head into the output register and go to SEND_A (dest 0) or SEND_B (dest 1).
  - SEND_A: `a_valid`=1 and `a_data`=reg; hold until `a_ready`. On handshake: if FIFO non-empty, pop the next entry into the register and go to SEND_A/SEND_B per its tag in the same cycle; else go to IDLE.
  - SEND_B: symmetric on `b_valid`/`b_ready`.
- Strict in-order delivery. A stalled destination blocks the other (head-of-line); no reordering.
- `a_data`/`b_data` are forced to 16'h0000 whenever the corresponding valid is low.
- `busy` = (occupancy != 0) || (state != IDLE).
- Reset: FIFO empty, pointers 0, state IDLE.
  - All outputs 0: `a_valid`, `b_valid`, data, `busy`, counters.
  - `in_ready` is 0 while `rst` is high and 1 on the first cycle after reset.
  - Reset mid-transfer discards the buffered word and the in-flight word without a handshake.

## Timing
- Latency: a word pushed at edge N into an empty block with an idle FSM presents valid after edge N+1. Minimum latency is 1 cycle after acceptance; there is no combinational in-to-out path.
- Throughput: 1 word/cycle sustained when the selected destination holds ready high.
- A destination switch (A→B) costs no bubble.
- Valid and data are stable until the handshake; valid never drops without a handshake except on reset.
- `in_ready` deasserts in the cycle the count reaches DEPTH. It reasserts the cycle after a pop from full.
- Pointer wrap: DEPTH-1 → 0, with no lost or duplicated entries.

## Configuration
- `ROUTE_CNT_EN` defined:
  - Two 16-bit counters `cnt_a`/`cnt_b` increment on each A/B handshake.
  - They wrap 16'hFFFF → 16'h0000 and reset to 0.
- Not defined: the `cnt_a`/`cnt_b` ports and counter logic are absent; all other behaviour is identical.

## Test plan
- Post-reset idle: hold `rst` 2 cycles, then release. Require all outputs 0 during reset, then `in_ready`=1 and `busy`=0.
- Alternating routing:
  - Stimulus: push 16'h1111 (dest 0), 16'h2222 (dest 1), 16'h3333 (dest 0); both readies held high.
  - A sees 1111, then B sees 2222, then A sees 3333 on consecutive cycles.
  - The idle side's data stays 0.
- Backpressure/full:
  - Stimulus: `a_ready`=0; push DEPTH+1 words to dest 0.
  - Require 1 word in the output register, DEPTH in the FIFO, and `in_ready`=0.
  - Raise `a_ready`: all words drain in order, one per cycle; `in_ready` returns the cycle after the first pop from full.
- Head-of-line:
  - Stimulus: dest-0 word with `a_ready`=0, followed by a dest-1 word with `b_ready`=1.
  - Require `b_valid` to stay 0 until the A handshake completes.
- Wrap plus simultaneous push/pop: stream 3×DEPTH words with ready toggling pseudo-randomly. Require order and values preserved and no duplicates.
- Reset mid-operation and counters:
  - With `ROUTE_CNT_EN`, complete 5 A and 3 B transfers; require `cnt_a`=5, `cnt_b`=3.
  - Assert `rst` while SEND_B is stalled with the FIFO holding 2 words.
  - Require the counters to read 0 and both valids 0, and no stale word to emerge afterward.
